aes_job_scheduler: RTL and testbench
====================================

// Module: aes_job_scheduler
// PURPOSE
//  Shares one AES-128 core (main FSM + key-schedule/round datapath) between NREQ requesters.
//  Round-robin arbitration; captures the winner's key/data/direction and launches the core.
//  Requests keyChange only when the key differs from the last expanded key.
//  Returns the result to the owning requester; a watchdog recovers from a hung core.
// PARAMETERS
//  NREQ      4     number of requesters, 2..8
//  TIMEOUT   64    max cycles in WAIT before abort, must be >= 40
// PORTS
//  clk            in   1         clock
//  reset          in   1         async active-high reset
//  req_valid      in   NREQ      per-requester job request
//  req_ready      out  NREQ      one-hot accept pulse
//  req_encrypt    in   NREQ      1=encrypt, 0=decrypt
//  req_key        in   NREQ*128  key of requester r at [r*128 +: 128]
//  req_data       in   NREQ*128  plaintext/ciphertext of requester r at [r*128 +: 128]
//  rsp_valid      out  NREQ      one-hot result valid
//  rsp_ready      in   NREQ      per-requester result accept
//  rsp_data       out  128       result, shared by all requesters
//  rsp_err        out  1         result aborted by timeout; rsp_data=0
//  core_start     out  1         one-cycle launch pulse to core
//  core_sel_cypher out 1         to core selCypher
//  core_key_change out 1         to core keyChange, valid with core_start
//  core_key       out  128       captured key
//  core_data      out  128       captured block
//  core_done      in   1         core result valid, one-cycle pulse
//  core_result    in   128       core output block
// BEHAVIOUR
//  Reset is asynchronous and active-high on clk. Every output resets to 0.
//  State resets to IDLE. rr_ptr=0, key_cache_vld=0.
//  FSM: IDLE -> LAUNCH -> WAIT -> RESP -> IDLE.
//  - IDLE: if any req_valid, grant the first set bit searching from rr_ptr upward (wrapping).
//    Assert req_ready[g] combinationally this cycle only; req_ready=0 in all other states.
//    Capture owner=g, key, data and encrypt into registers. Go to LAUNCH.
//  - LAUNCH: core_start=1 for exactly 1 cycle.
//    core_key_change = !key_cache_vld || (cap_key != cache_key).
//    Then set cache_key=cap_key and key_cache_vld=1. Clear wd_cnt. Go to WAIT.
//  - WAIT: wd_cnt increments every cycle.
//    core_done=1: latch core_result into rsp_data, rsp_err=0, go to RESP.
//    wd_cnt==TIMEOUT-1 without done: rsp_data=0, rsp_err=1, key_cache_vld=0, go to RESP.
//    core_done arriving in the timeout cycle counts as success.
//  - RESP: hold rsp_valid[owner]=1, rsp_data and rsp_err stable until rsp_ready[owner].
//    Other rsp_ready bits are ignored. On handshake: rr_ptr=(owner+1)%NREQ, go to IDLE.
//  - core_sel_cypher, core_key and core_data are held from LAUNCH through RESP.
//  Timing and boundaries:
//  - Grant-to-start latency is 1 cycle; done-to-rsp_valid latency is 1 cycle.
//  - New requests arriving in LAUNCH/WAIT/RESP wait (req_ready=0). Requesters hold req_valid.
//  - A requester that drops req_valid before grant loses its slot; it is not an error.
//  - core_done outside WAIT is ignored.
//  - The same requester re-requesting in the cycle after RESP is granted only if no other valid.
//  - rr_ptr wraps from NREQ-1 to 0.
//  - A reset mid-job drops the job silently. The key cache is invalidated, so the next job asserts core_key_change=1.
// STRUCTURE
//  Package aes_sched_pkg: AES_BLK_W=128; typedef enum logic[1:0] {S_IDLE,S_LAUNCH,S_WAIT,S_RESP} sched_state_t;
//    helper function for the key compare.
//  Sub-module rr_arbiter #(N): inputs req, ptr, en; outputs one-hot gnt and binary gnt_idx.
//    Purely combinational.
//  Top level holds the FSM, capture registers, key cache and watchdog counter.
// TESTING
//  1 Single: req_valid=4'b0010, enc=1, key K1, data P.
//    -> req_ready=0010 for 1 cycle; core_start the next cycle with key_change=1 and sel_cypher=1.
//    -> done with C -> rsp_valid=0010, rsp_data=C, err=0.
//  2 Key reuse: repeat scenario 1 with the same K1, enc=0, data C.
//    -> core_key_change=0, core_sel_cypher=0. Then a K2 job -> key_change=1.
//  3 Round robin: req_valid=1111 held; each job completes.
//    -> grant order 0,1,2,3,0; rsp_valid one-hot and matching the owner each time.
//  4 Backpressure: rsp_ready[owner]=0 for 5 cycles.
//    -> rsp_valid and rsp_data stable; no new req_ready; core_start stays 0.
//  5 Timeout: no core_done for TIMEOUT cycles.
//    -> rsp_err=1, rsp_data=0. Next job with the same key has key_change=1.
//  6 Reset in WAIT: all outputs 0 the same cycle.
//    -> after release, a stale core_done is ignored; the next job uses rr_ptr=0 and key_change=1.

Source files
------------

// File: rtl/aes_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : aes_sched_pkg
//  Purpose : Shared types and helpers for the AES job scheduler.
//            AES_BLK_W      - AES block / key width in bits
//            sched_state_t  - scheduler FSM state encoding
//            key_differs()  - key-cache comparison helper
//  Rev     : 1.0  initial release
// ============================================================================
package aes_sched_pkg;

  localparam int AES_BLK_W = 128;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } sched_state_t;

  // True when the key about to be used is not the one the core last expanded.
  function automatic logic key_differs(input logic [AES_BLK_W-1:0] new_key,
                                       input logic [AES_BLK_W-1:0] cached_key);
    return (new_key != cached_key);
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_job_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : rr_arbiter
//  Purpose : Combinational round-robin arbiter. Grants the first set request
//            bit found searching upward from ptr, wrapping at N-1 -> 0.
//  Ports   : req     in  N    request vector
//            ptr     in  IW   highest-priority index
//            en      in  1    arbitration enable; gnt=0 when low
//            gnt     out N    one-hot grant
//            gnt_idx out IW   binary index of the grant (0 when no grant)
//  Rev     : 1.0  initial release
// ============================================================================
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  // Walk the rotated order from farthest to nearest so the candidate closest
  // to ptr is the last one written and therefore wins.
  always_comb begin
    int idx;
    gnt     = '0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (en && req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        gnt_idx  = IW'(idx);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/aes_job_scheduler.sv
`default_nettype none
// ============================================================================
//  Module  : aes_job_scheduler
//  Purpose : Shares one AES-128 core between NREQ requesters. Round-robin
//            grant, capture of key/data/direction, core launch with
//            keyChange only on a key-cache miss, result return to the owner
//            and a watchdog that aborts a hung core.
//  Ports   : clk, reset          clock, async active-high reset
//            req_valid/ready     per-requester request / one-hot accept pulse
//            req_encrypt         1=encrypt, 0=decrypt
//            req_key/req_data    packed per-requester 128-bit key / block
//            rsp_valid/ready     one-hot result valid / per-requester accept
//            rsp_data, rsp_err   shared result, timeout flag (data=0 on err)
//            core_*              launch interface to / result from AES core
//  Rev     : 1.0  initial release
// ============================================================================
module aes_job_scheduler
  import aes_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ-1:0]           req_encrypt,
  input  logic [NREQ*AES_BLK_W-1:0] req_key,
  input  logic [NREQ*AES_BLK_W-1:0] req_data,
  output logic [NREQ-1:0]           rsp_valid,
  input  logic [NREQ-1:0]           rsp_ready,
  output logic [AES_BLK_W-1:0]      rsp_data,
  output logic                      rsp_err,
  output logic                      core_start,
  output logic                      core_sel_cypher,
  output logic                      core_key_change,
  output logic [AES_BLK_W-1:0]      core_key,
  output logic [AES_BLK_W-1:0]      core_data,
  input  logic                      core_done,
  input  logic [AES_BLK_W-1:0]      core_result
);

  localparam int IW      = $clog2(NREQ);
  localparam int WDW     = $clog2(TIMEOUT) + 1;
  localparam int WD_LAST = TIMEOUT - 1;

  sched_state_t         state_q,     state_d;
  logic [IW-1:0]        owner_q,     owner_d;
  logic [IW-1:0]        rr_ptr_q,    rr_ptr_d;
  logic [AES_BLK_W-1:0] cap_key_q,   cap_key_d;
  logic [AES_BLK_W-1:0] cap_data_q,  cap_data_d;
  logic                 cap_enc_q,   cap_enc_d;
  logic [AES_BLK_W-1:0] cache_key_q, cache_key_d;
  logic                 cache_vld_q, cache_vld_d;
  logic [WDW-1:0]       wd_cnt_q,    wd_cnt_d;
  logic [AES_BLK_W-1:0] rsp_data_q,  rsp_data_d;
  logic                 rsp_err_q,   rsp_err_d;

  logic [AES_BLK_W-1:0] w_req_key  [NREQ];
  logic [AES_BLK_W-1:0] w_req_data [NREQ];
  logic [NREQ-1:0]      w_gnt;
  logic [IW-1:0]        w_gnt_idx;
  logic                 w_arb_en;

  for (genvar r = 0; r < NREQ; r++) begin : g_unpack
    assign w_req_key[r]  = req_key [r*AES_BLK_W +: AES_BLK_W];
    assign w_req_data[r] = req_data[r*AES_BLK_W +: AES_BLK_W];
  end

  // Reset gates the enable so req_ready is 0 while reset is held, even
  // though the state register already reads IDLE.
  assign w_arb_en = (state_q == S_IDLE) && !reset;

  rr_arbiter #(
    .N  (NREQ),
    .IW (IW)
  ) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .en      (w_arb_en),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    cap_key_d   = cap_key_q;
    cap_data_d  = cap_data_q;
    cap_enc_d   = cap_enc_q;
    cache_key_d = cache_key_q;
    cache_vld_d = cache_vld_q;
    wd_cnt_d    = wd_cnt_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      S_IDLE: begin
        if (|w_gnt) begin
          owner_d    = w_gnt_idx;
          cap_key_d  = w_req_key[w_gnt_idx];
          cap_data_d = w_req_data[w_gnt_idx];
          cap_enc_d  = req_encrypt[w_gnt_idx];
          state_d    = S_LAUNCH;
        end
      end

      S_LAUNCH: begin
        cache_key_d = cap_key_q;
        cache_vld_d = 1'b1;
        wd_cnt_d    = '0;
        state_d     = S_WAIT;
      end

      S_WAIT: begin
        wd_cnt_d = wd_cnt_q + WDW'(1);
        // A done in the final watchdog cycle still wins over the abort.
        if (core_done) begin
          rsp_data_d = core_result;
          rsp_err_d  = 1'b0;
          state_d    = S_RESP;
        end else if (wd_cnt_q == WDW'(WD_LAST)) begin
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          // The core's key schedule state is unknown after an abort.
          cache_vld_d = 1'b0;
          state_d     = S_RESP;
        end
      end

      S_RESP: begin
        if (rsp_ready[owner_q]) begin
          rr_ptr_d = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
          state_d  = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      cap_key_q   <= '0;
      cap_data_q  <= '0;
      cap_enc_q   <= 1'b0;
      cache_key_q <= '0;
      cache_vld_q <= 1'b0;
      wd_cnt_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      cap_key_q   <= cap_key_d;
      cap_data_q  <= cap_data_d;
      cap_enc_q   <= cap_enc_d;
      cache_key_q <= cache_key_d;
      cache_vld_q <= cache_vld_d;
      wd_cnt_q    <= wd_cnt_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready       = w_gnt;
  assign rsp_valid       = (state_q == S_RESP) ? (NREQ'(1) << owner_q) : '0;
  assign rsp_data        = rsp_data_q;
  assign rsp_err         = rsp_err_q;
  assign core_start      = (state_q == S_LAUNCH);
  assign core_key_change = (state_q == S_LAUNCH) &&
                           (!cache_vld_q || key_differs(cap_key_q, cache_key_q));
  assign core_sel_cypher = cap_enc_q;
  assign core_key        = cap_key_q;
  assign core_data       = cap_data_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_job_scheduler.sv
`default_nettype none
// ============================================================================
//  Module  : tb_aes_job_scheduler
//  Purpose : Randomized self-checking bench for aes_job_scheduler with a
//            behavioural core model and a response scoreboard.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_aes_job_scheduler;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 64;
  localparam int W       = 128;
  localparam int NJOBS   = 40;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid, req_ready, req_encrypt;
  logic [NREQ*W-1:0] req_key, req_data;
  logic [NREQ-1:0]   rsp_valid, rsp_ready;
  logic [W-1:0]      rsp_data;
  logic              rsp_err;
  logic              core_start, core_sel_cypher, core_key_change;
  logic [W-1:0]      core_key, core_data;
  logic              core_done;
  logic [W-1:0]      core_result;

  always #5 clk = ~clk;

  aes_job_scheduler #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_encrypt     (req_encrypt),
    .req_key         (req_key),
    .req_data        (req_data),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_data        (rsp_data),
    .rsp_err         (rsp_err),
    .core_start      (core_start),
    .core_sel_cypher (core_sel_cypher),
    .core_key_change (core_key_change),
    .core_key        (core_key),
    .core_data       (core_data),
    .core_done       (core_done),
    .core_result     (core_result)
  );

  typedef struct {
    int         owner;
    logic       enc;
    logic [W-1:0] key;
    logic [W-1:0] data;
    int         d;       // cycles from launch to core_done
    logic       kc;      // expected keyChange
    logic [W-1:0] res;   // expected rsp_data
    logic       err;     // expected rsp_err
  } job_t;

  job_t launch_q[$];
  job_t rsp_q[$];

  int   total = 0;
  int   bad   = 0;
  bit   busy = 0, in_job = 0, inject_stale = 0, force_hang = 0;
  int   cnt = 0;
  logic [W-1:0] core_res_hold;

  // Reference model state
  int           m_ptr  = 0;
  bit           m_cvld = 0;
  logic [W-1:0] m_ckey = '0;

  logic [NREQ-1:0] pending;
  logic [W-1:0]    p_key  [NREQ];
  logic [W-1:0]    p_data [NREQ];
  logic            p_enc  [NREQ];
  logic [W-1:0]    key_pool [3];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] core_fn(input logic [W-1:0] k, input logic [W-1:0] d,
                                           input logic e);
    return {k[63:0], k[127:64]} ^ d ^ {W{e}};
  endfunction

  function automatic int exp_winner(input logic [NREQ-1:0] m, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (m[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drive_reqs();
    req_valid = pending;
    for (int r = 0; r < NREQ; r++) begin
      req_key [r*W +: W] = p_key[r];
      req_data[r*W +: W] = p_data[r];
      req_encrypt[r]     = p_enc[r];
    end
  endtask

  task automatic new_job(input int r);
    pending[r] = 1'b1;
    p_key[r]   = key_pool[$urandom % 3];
    p_data[r]  = rnd128();
    p_enc[r]   = 1'($urandom);
  endtask

  // Waits for a grant, checks it against the model and queues expectations.
  task automatic take_grant(output bit ok);
    int   g;
    int   sel;
    job_t e;
    logic [NREQ-1:0] exp_rdy;
    ok = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (req_ready != 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL grant_wait: got no req_ready within 400 cycles expected a grant");
      return;
    end
    chk("grant_while_busy", W'(busy), W'(0));
    g = exp_winner(pending, m_ptr);
    exp_rdy = (g < 0) ? '0 : NREQ'(1) << g;
    chk("req_ready", W'(req_ready), W'(exp_rdy));
    if (g < 0) g = 0;
    e.owner = g;
    e.enc   = p_enc[g];
    e.key   = p_key[g];
    e.data  = p_data[g];
    sel = $urandom % 10;
    if (force_hang)    e.d = 5000;
    else if (sel == 0) e.d = TIMEOUT;
    else if (sel == 1) e.d = TIMEOUT + 1 + ($urandom % 4);
    else               e.d = 1 + ($urandom % 20);
    e.err = (e.d > TIMEOUT);
    e.res = e.err ? '0 : core_fn(e.key, e.data, e.enc);
    e.kc  = !m_cvld || (m_ckey != e.key);
    m_ckey = e.key;
    m_cvld = !e.err;
    m_ptr  = (g + 1) % NREQ;
    launch_q.push_back(e);
    rsp_q.push_back(e);
    busy = 1;
    pending[g] = 1'b0;
    @(posedge clk); #1;
    drive_reqs();
    @(negedge clk);
    chk("req_ready_pulse", W'(req_ready), W'(0));
    chk("start_latency", W'(core_start), W'(1));
  endtask

  task automatic run_one(output bit ok);
    @(posedge clk); #1;
    for (int r = 0; r < NREQ; r++)
      if (!pending[r] && ($urandom % 2 == 1)) new_job(r);
    if ($urandom % 8 == 0) pending[$urandom % NREQ] = 1'b0;
    if (pending == 0) new_job($urandom % NREQ);
    drive_reqs();
    take_grant(ok);
  endtask

  task automatic drain();
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (!busy && rsp_q.size() == 0) return;
    end
    total++; bad++;
    $display("FAIL drain: got %0d responses outstanding expected 0", rsp_q.size());
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"},  W'(req_ready),       W'(0));
    chk({tag, "_rsp_valid"},  W'(rsp_valid),       W'(0));
    chk({tag, "_rsp_data"},   rsp_data,            W'(0));
    chk({tag, "_rsp_err"},    W'(rsp_err),         W'(0));
    chk({tag, "_core_start"}, W'(core_start),      W'(0));
    chk({tag, "_core_kc"},    W'(core_key_change), W'(0));
    chk({tag, "_core_sel"},   W'(core_sel_cypher), W'(0));
    chk({tag, "_core_key"},   core_key,            W'(0));
    chk({tag, "_core_data"},  core_data,           W'(0));
  endtask

  // Requester result acceptance with random backpressure.
  initial begin
    rsp_ready = '0;
    forever begin
      @(posedge clk); #1;
      rsp_ready = NREQ'($urandom);
    end
  end

  // Core model: answers a launch after e.d cycles; emits stray dones when idle.
  initial begin
    core_done   = 1'b0;
    core_result = '0;
    forever begin
      @(posedge clk); #1;
      core_done = 1'b0;
      if (inject_stale) begin
        core_done    = 1'b1;
        core_result  = rnd128();
        inject_stale = 0;
      end else if (in_job) begin
        cnt--;
        if (cnt <= 0) begin
          core_done   = 1'b1;
          core_result = core_res_hold;
          in_job      = 0;
        end
      end else if ($urandom % 6 == 0) begin
        core_done   = 1'b1;
        core_result = rnd128();
      end
    end
  end

  // Launch watcher: checks core inputs against the queued job.
  initial begin
    job_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_job = 0;
      end else if (core_start === 1'b1) begin
        if (launch_q.size() == 0) begin
          total++; bad++;
          $display("FAIL core_start: got unexpected launch expected none");
        end else begin
          e = launch_q.pop_front();
          chk("core_key_change", W'(core_key_change), W'(e.kc));
          chk("core_sel_cypher", W'(core_sel_cypher), W'(e.enc));
          chk("core_key",        core_key,            e.key);
          chk("core_data",       core_data,           e.data);
          cnt           = e.d;
          core_res_hold = e.err ? rnd128() : core_fn(e.key, e.data, e.enc);
          in_job        = 1;
        end
      end
    end
  end

  // Response monitor / scoreboard.
  initial begin
    job_t e;
    forever begin
      @(negedge clk);
      if (!reset && rsp_valid != 0) begin
        if (rsp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL rsp_valid: got %b with no job outstanding expected 0", rsp_valid);
        end else begin
          e = rsp_q[0];
          chk("rsp_valid",     W'(rsp_valid),       W'(NREQ'(1) << e.owner));
          chk("rsp_data",      rsp_data,            e.res);
          chk("rsp_err",       W'(rsp_err),         W'(e.err));
          chk("resp_no_start", W'(core_start),      W'(0));
          chk("resp_key_hold", core_key,            e.key);
          chk("resp_sel_hold", W'(core_sel_cypher), W'(e.enc));
          if (rsp_ready[e.owner]) begin
            void'(rsp_q.pop_front());
            busy = 0;
          end
        end
      end
    end
  end

  initial begin
    #3000000;
    total++; bad++;
    $display("FAIL watchdog: got no completion expected finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    bit ok;
    ok = 1;
    for (int i = 0; i < 3; i++) key_pool[i] = rnd128();
    for (int r = 0; r < NREQ; r++) begin
      p_key[r] = '0; p_data[r] = '0; p_enc[r] = 1'b0;
    end
    reset       = 1'b1;
    req_valid   = '1;
    req_encrypt = '1;
    req_key     = '1;
    req_data    = '1;
    pending     = '0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    reset     = 1'b0;
    req_valid = '0;

    for (int j = 0; j < NJOBS && ok; j++) run_one(ok);
    drain();

    // Reset while the core is busy: a job on requester 2 that never finishes.
    if (ok) begin
      @(posedge clk); #1;
      pending = '0;
      new_job(2);
      force_hang = 1;
      drive_reqs();
      take_grant(ok);
      force_hang = 0;
      repeat (3) @(negedge clk);
      #2;
      req_valid = '1;
      reset     = 1'b1;
      in_job    = 0;
      #1;
      chk_all_zero("rst_wait");
      launch_q.delete();
      rsp_q.delete();
      busy   = 0;
      m_ptr  = 0;
      m_cvld = 0;
      @(posedge clk);
      @(posedge clk); #1;
      reset        = 1'b0;
      pending      = '0;
      req_valid    = '0;
      inject_stale = 1;
      repeat (3) begin
        @(negedge clk);
        chk("stale_done_ignored", W'(rsp_valid), W'(0));
      end
      // All four requesters valid: pointer restarted at 0, cache is cold.
      @(posedge clk); #1;
      for (int r = 0; r < NREQ; r++) new_job(r);
      p_key[0] = p_key[2];
      drive_reqs();
      take_grant(ok);
      for (int j = 0; j < 3 && ok; j++) run_one(ok);
      drain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
